// File: rtl/mux_nch_scan.sv
// mux_nch_scan: N-channel, WIDTH-bit registered multiplexer with MANUAL and
// SCAN modes. SCAN steps channels 0..NCH-1, spending DWELL cycles on each,
// and pulses scan_wrap on the NCH-1 -> 0 step.
// Optional build macro: MUX_SCAN_PARITY_EN adds the registered parity output y_par.
module mux_nch_scan #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  output logic [WIDTH-1:0]       y,
  output logic                   y_valid,
  output logic [SEL_W-1:0]       sel_out,
  output logic                   scan_wrap
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                   y_par
`endif
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]   NCH_L    = (SEL_W+1)'(NCH);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] scan_sel;
  logic [CNT_W-1:0] scan_cnt;

  logic [WIDTH-1:0] y_p1, y_p0;
  logic             vld_p1, vld_p0;
  logic [SEL_W-1:0] sel_p1, sel_p0;
  logic             wrap_p1, wrap_p0;
  logic             par_p1, par_p0;

  // Channel select without X: an out-of-range index yields zero.
  function automatic logic [WIDTH-1:0] pick(input logic [NCH*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (s == SEL_W'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic legal(input logic [SEL_W-1:0] s);
    return ({1'b0, s} < NCH_L);
  endfunction

  function automatic logic parity(input logic [WIDTH-1:0] v, input logic ok);
    return ok & (^v);
  endfunction

  // Next-state, scan counters and next output sample.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    scan_sel  = '0;
    scan_cnt  = '0;
    y_p0      = y_p1;
    sel_p0    = sel_p1;
    vld_p0    = 1'b0;
    wrap_p0   = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          // Mode is latched into the state; no sample this cycle.
          state_nxt = mode ? ST_SCAN : ST_MANUAL;
          sel_nxt   = '0;
          cnt_nxt   = '0;
        end
        ST_MANUAL, ST_SCAN: begin
          if (!mode) begin
            // Leaving SCAN here overrides any dwell expiry this cycle.
            state_nxt = ST_MANUAL;
            sel_nxt   = '0;
            cnt_nxt   = '0;
            sel_p0    = sel_in;
            if (legal(sel_in)) begin
              y_p0   = pick(din, sel_in);
              vld_p0 = 1'b1;
            end else begin
              y_p0   = '0;
              vld_p0 = 1'b0;
            end
          end else begin
            // Entering SCAN from MANUAL starts at channel 0 with a fresh dwell.
            scan_sel  = (state == ST_SCAN) ? sel : '0;
            scan_cnt  = (state == ST_SCAN) ? cnt : '0;
            state_nxt = ST_SCAN;
            y_p0      = pick(din, scan_sel);
            sel_p0    = scan_sel;
            vld_p0    = 1'b1;
            if (scan_cnt == LAST_CNT) begin
              cnt_nxt = '0;
              if (scan_sel == LAST_SEL) begin
                sel_nxt = '0;
                wrap_p0 = 1'b1;
              end else begin
                sel_nxt = scan_sel + 1'b1;
              end
            end else begin
              cnt_nxt = scan_cnt + 1'b1;
              sel_nxt = scan_sel;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          sel_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
    par_p0 = parity(y_p0, vld_p0);
  end

  // Stage p0 -> p1: FSM state, scan counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel     <= '0;
      cnt     <= '0;
      y_p1    <= '0;
      vld_p1  <= 1'b0;
      sel_p1  <= '0;
      wrap_p1 <= 1'b0;
      par_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      cnt     <= cnt_nxt;
      y_p1    <= y_p0;
      vld_p1  <= vld_p0;
      sel_p1  <= sel_p0;
      wrap_p1 <= wrap_p0;
      par_p1  <= par_p0;
    end
  end

  assign y         = y_p1;
  assign y_valid   = vld_p1;
  assign sel_out   = sel_p1;
  assign scan_wrap = wrap_p1;

`ifdef MUX_SCAN_PARITY_EN
  assign y_par = par_p1;
`else
  logic unused_par;
  assign unused_par = par_p1;
`endif

endmodule
